// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin front end sharing one restoring divider (one quotient bit per cycle).
// Optional feature macro DIVIDER_ARBITER_ZERO_BYPASS_EN: a zero divider skips RUN and completes at accept.
module divider_arbiter #(
   parameter int INPUT_BIT_WIDTH = 8,
   parameter int NUM_REQ         = 4,
   parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
   input  logic                               Clk,
   input  logic                               Rst_n,
   input  logic [NUM_REQ-1:0]                 ReqValid,
   input  logic [NUM_REQ*INPUT_BIT_WIDTH-1:0] ReqDividend,
   input  logic [NUM_REQ*INPUT_BIT_WIDTH-1:0] ReqDivider,
   output logic [NUM_REQ-1:0]                 ReqReady,
   output logic                               RespValid,
   input  logic                               RespReady,
   output logic [ID_WIDTH-1:0]                RespId,
   output logic [INPUT_BIT_WIDTH-1:0]         Quotient,
   output logic [INPUT_BIT_WIDTH-1:0]         Remainder,
   output logic                               DivByZero
);

   localparam int W     = INPUT_BIT_WIDTH;
   localparam int CNT_W = $clog2(W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_q, state_d;
   logic [ID_WIDTH-1:0] last_q, last_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [W-1:0]        quo_q, quo_d;
   logic [W-1:0]        rmd_q, rmd_d;
   logic                dbz_q, dbz_d;
   logic                vld_q, vld_d;
   logic [W-1:0]        dvd_q, dvd_d;
   logic [W-1:0]        dvs_q, dvs_d;
   logic [W-1:0]        part_q, part_d;

   logic [NUM_REQ-1:0]  gnt_oh;
   logic [ID_WIDTH-1:0] gnt_idx;
   logic                gnt_any;
   logic [W-1:0]        acc_dvd, acc_dvs;
   logic [W:0]          shifted, diff;
   logic                qbit;
   logic [W-1:0]        part_next, quo_next;

   // Rotating priority: candidate order last+1, last+2, ... with wrap.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      acc_dvd = '0;
      acc_dvs = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && ReqValid[i] &&
                ((int'(last_q) + k == i) || (int'(last_q) + k == i + NUM_REQ))) begin
               gnt_any    = 1'b1;
               gnt_oh[i]  = 1'b1;
               gnt_idx    = ID_WIDTH'(i);
               acc_dvd    = ReqDividend[i*W +: W];
               acc_dvs    = ReqDivider[i*W +: W];
            end
         end
      end
   end

   // Restoring step on a W+1-bit partial remainder; bit W of diff is the borrow.
   always_comb begin
      shifted   = {part_q, dvd_q[W-1]};
      diff      = shifted - {1'b0, dvs_q};
      qbit      = ~diff[W];
      part_next = qbit ? diff[W-1:0] : shifted[W-1:0];
      quo_next  = {dvd_q[W-2:0], qbit};
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      vld_d   = vld_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      part_d  = part_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               dvd_d   = acc_dvd;
               dvs_d   = acc_dvs;
               part_d  = '0;
               cnt_d   = '0;
               id_d    = gnt_idx;
               last_d  = gnt_idx;
               state_d = RUN;
`ifdef DIVIDER_ARBITER_ZERO_BYPASS_EN
               if (acc_dvs == '0) begin
                  quo_d   = '1;
                  rmd_d   = acc_dvd;
                  dbz_d   = 1'b1;
                  vld_d   = 1'b1;
                  state_d = DONE;
               end
`endif
            end
         end
         RUN: begin
            // The dividend register doubles as the quotient shift register.
            part_d = part_next;
            dvd_d  = quo_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) begin
               quo_d   = quo_next;
               rmd_d   = part_next;
               dbz_d   = (dvs_q == '0);
               vld_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (RespReady) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         last_q  <= ID_WIDTH'(NUM_REQ - 1);
         id_q    <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
         vld_q   <= vld_d;
      end
   end

   // Working operands are only meaningful inside RUN, so they carry no reset.
   always_ff @(posedge Clk) begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      part_q <= part_d;
   end

   assign ReqReady  = (state_q == IDLE) ? gnt_oh : '0;
   assign RespValid = vld_q;
   assign RespId    = id_q;
   assign Quotient  = quo_q;
   assign Remainder = rmd_q;
   assign DivByZero = dbz_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: randomized and directed checks of divider_arbiter against a behavioural model.
module tb_divider_arbiter;

   localparam int W   = 8;
   localparam int N   = 4;
   localparam int IDW = 2;
`ifdef DIVIDER_ARBITER_ZERO_BYPASS_EN
   localparam int ZLAT = 0;
`else
   localparam int ZLAT = W;
`endif

   logic             Clk = 1'b0;
   logic             Rst_n = 1'b1;
   logic [N-1:0]     ReqValid;
   logic [N*W-1:0]   ReqDividend;
   logic [N*W-1:0]   ReqDivider;
   logic [N-1:0]     ReqReady;
   logic             RespValid;
   logic             RespReady;
   logic [IDW-1:0]   RespId;
   logic [W-1:0]     Quotient;
   logic [W-1:0]     Remainder;
   logic             DivByZero;

   int total = 0;
   int bad   = 0;
   int exp_last = N - 1;

   divider_arbiter #(.INPUT_BIT_WIDTH(W), .NUM_REQ(N), .ID_WIDTH(IDW)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqDividend(ReqDividend),
      .ReqDivider(ReqDivider), .ReqReady(ReqReady), .RespValid(RespValid),
      .RespReady(RespReady), .RespId(RespId), .Quotient(Quotient),
      .Remainder(Remainder), .DivByZero(DivByZero)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int exp_grant(input logic [N-1:0] m, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (m[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] exp_q(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return {W{1'b1}};
      return a / b;
   endfunction

   function automatic logic [W-1:0] exp_r(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return a;
      return a % b;
   endfunction

   function automatic int exp_lat(input logic [W-1:0] b);
      return (b == 0) ? ZLAT : W;
   endfunction

   task automatic set_data(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      ReqDividend[idx*W +: W] = a;
      ReqDivider[idx*W +: W]  = b;
   endtask

   task automatic wait_grant(input int idx);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (ReqReady[idx]) begin
            ok = 1'b1;
            break;
         end
         @(posedge Clk); #1;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL grant_timeout: req %0d got no grant, ReqReady=%b", idx, ReqReady);
      end
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      while (!RespValid && lat < 64) begin
         @(posedge Clk); #1;
         lat++;
      end
   endtask

   task automatic do_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      set_data(idx, a, b);
      ReqValid[idx] = 1'b1;
      wait_grant(idx);
      @(posedge Clk); #1;
      ReqValid[idx] = 1'b0;
      exp_last = idx;
      set_data(idx, W'($urandom), W'($urandom));
      wait_resp(lat);
   endtask

   task automatic apply_reset();
      Rst_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      exp_last = N - 1;
   endtask

   task automatic test_reset();
      #2;
      Rst_n = 1'b0;
      #1;
      total++;
      if ({RespValid, Quotient, Remainder, RespId, DivByZero} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got v=%b q=%0d r=%0d id=%0d z=%b want all 0",
                  RespValid, Quotient, Remainder, RespId, DivByZero);
      end
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      exp_last = N - 1;
      ReqValid = '1;
      #1;
      total++;
      if (ReqReady !== 4'b0001) begin
         bad++;
         $display("FAIL reset_priority: ReqReady got %b want 0001", ReqReady);
      end
      ReqValid = '0;
   endtask

   task automatic test_basic();
      int lat;
      do_op(0, 8'd100, 8'd7, lat);
      total++;
      if (lat !== W) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
      total++;
      if ({RespId, Quotient, Remainder, DivByZero} !== {2'd0, 8'd14, 8'd2, 1'b0}) begin
         bad++;
         $display("FAIL basic_result: got id=%0d q=%0d r=%0d z=%b want id=0 q=14 r=2 z=0",
                  RespId, Quotient, Remainder, DivByZero);
      end
      @(posedge Clk); #1;
      total++;
      if (RespValid !== 1'b0) begin bad++; $display("FAIL basic_consume: RespValid got %b want 0", RespValid); end
   endtask

   task automatic test_boundaries();
      logic [W-1:0] av [4] = '{8'd255, 8'd200, 8'd255, 8'd128};
      logic [W-1:0] bv [4] = '{8'd1, 8'd255, 8'd255, 8'd3};
      int lat;
      for (int k = 0; k < 4; k++) begin
         do_op(k, av[k], bv[k], lat);
         total++;
         if ({RespId, Quotient, Remainder, DivByZero} !== {IDW'(k), exp_q(av[k], bv[k]), exp_r(av[k], bv[k]), 1'b0}) begin
            bad++;
            $display("FAIL boundary_%0d: got id=%0d q=%0d r=%0d z=%b want id=%0d q=%0d r=%0d z=0",
                     k, RespId, Quotient, Remainder, DivByZero, k, exp_q(av[k], bv[k]), exp_r(av[k], bv[k]));
         end
         @(posedge Clk); #1;
      end
   endtask

   task automatic test_div_zero();
      int lat;
      do_op(2, 8'd77, 8'd0, lat);
      total++;
      if (lat !== ZLAT) begin bad++; $display("FAIL zero_latency: got %0d want %0d", lat, ZLAT); end
      total++;
      if ({RespId, Quotient, Remainder, DivByZero} !== {2'd2, 8'd255, 8'd77, 1'b1}) begin
         bad++;
         $display("FAIL zero_result: got id=%0d q=%0d r=%0d z=%b want id=2 q=255 r=77 z=1",
                  RespId, Quotient, Remainder, DivByZero);
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      int lat;
      apply_reset();
      for (int i = 0; i < N; i++) set_data(i, W'(50 + 17 * i), W'(i + 3));
      ReqValid = '1;
      for (int s = 0; s < 5; s++) begin
         #1;
         total++;
         if (ReqReady !== (N'(1) << order[s])) begin
            bad++;
            $display("FAIL rr_grant_%0d: ReqReady got %b want one-hot %0d", s, ReqReady, order[s]);
         end
         @(posedge Clk); #1;
         exp_last = order[s];
         wait_resp(lat);
         total++;
         if ({RespId, Quotient, Remainder} !== {IDW'(order[s]), exp_q(W'(50 + 17 * order[s]), W'(order[s] + 3)),
                                                 exp_r(W'(50 + 17 * order[s]), W'(order[s] + 3))} || lat !== W) begin
            bad++;
            $display("FAIL rr_result_%0d: got id=%0d q=%0d r=%0d lat=%0d", s, RespId, Quotient, Remainder, lat);
         end
         @(posedge Clk);
      end
      #1;
      ReqValid = 4'b0100;
      #1;
      total++;
      if (ReqReady !== 4'b0100) begin bad++; $display("FAIL rr_serve2: ReqReady got %b want 0100", ReqReady); end
      @(posedge Clk); #1;
      exp_last = 2;
      ReqValid = '0;
      wait_resp(lat);
      @(posedge Clk); #1;
      ReqValid = 4'b1100;
      #1;
      total++;
      if (ReqReady !== (N'(1) << exp_grant(4'b1100, exp_last)) || ReqReady !== 4'b1000) begin
         bad++;
         $display("FAIL rr_after2: ReqReady got %b want 1000", ReqReady);
      end
      ReqValid = '0;
   endtask

   task automatic test_backpressure();
      int lat;
      RespReady = 1'b0;
      do_op(1, 8'd200, 8'd9, lat);
      ReqValid = '1;
      for (int c = 0; c < 5; c++) begin
         @(posedge Clk); #1;
         total++;
         if ({RespValid, RespId, Quotient, Remainder, ReqReady} !== {1'b1, 2'd1, 8'd22, 8'd2, 4'b0000}) begin
            bad++;
            $display("FAIL hold_%0d: got v=%b id=%0d q=%0d r=%0d rdy=%b want v=1 id=1 q=22 r=2 rdy=0000",
                     c, RespValid, RespId, Quotient, Remainder, ReqReady);
         end
      end
      RespReady = 1'b1;
      @(posedge Clk); #1;
      total++;
      if (RespValid !== 1'b0 || ReqReady !== (N'(1) << exp_grant('1, exp_last))) begin
         bad++;
         $display("FAIL release: got v=%b rdy=%b want v=0 rdy=one-hot %0d", RespValid, ReqReady, exp_grant('1, exp_last));
      end
      ReqValid = '0;
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int seen;
      ReqValid = '0;
      set_data(3, 8'd250, 8'd3);
      ReqValid[3] = 1'b1;
      wait_grant(3);
      @(posedge Clk); #1;
      ReqValid = '0;
      repeat (4) @(posedge Clk);
      #1;
      Rst_n = 1'b0;
      #1;
      total++;
      if ({RespValid, Quotient, Remainder, RespId, DivByZero, ReqReady} !== '0) begin
         bad++;
         $display("FAIL midrun_reset: got v=%b q=%0d r=%0d id=%0d z=%b rdy=%b want all 0",
                  RespValid, Quotient, Remainder, RespId, DivByZero, ReqReady);
      end
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      exp_last = N - 1;
      seen = 0;
      for (int c = 0; c < W + 3; c++) begin
         @(posedge Clk); #1;
         if (RespValid) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL midrun_no_resp: got %0d valid cycles want 0", seen); end
      set_data(1, 8'd99, 8'd10);
      set_data(3, 8'd45, 8'd4);
      ReqValid = 4'b1010;
      #1;
      total++;
      if (ReqReady !== 4'b0010) begin bad++; $display("FAIL midrun_regrant: ReqReady got %b want 0010", ReqReady); end
      @(posedge Clk); #1;
      exp_last = 1;
      ReqValid = '0;
      wait_resp(lat);
      total++;
      if ({RespId, Quotient, Remainder} !== {2'd1, 8'd9, 8'd9}) begin
         bad++;
         $display("FAIL midrun_result: got id=%0d q=%0d r=%0d want id=1 q=9 r=9", RespId, Quotient, Remainder);
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_random();
      logic [N-1:0] mask;
      logic [W-1:0] a [N];
      logic [W-1:0] b [N];
      int g, lat, hold;
      for (int it = 0; it < 24; it++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            a[i] = W'($urandom);
            b[i] = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 255));
            set_data(i, a[i], b[i]);
         end
         g = exp_grant(mask, exp_last);
         ReqValid = mask;
         #1;
         total++;
         if (ReqReady !== (N'(1) << g)) begin
            bad++;
            $display("FAIL rand_grant_%0d: ReqReady got %b want one-hot %0d (mask %b)", it, ReqReady, g, mask);
         end
         @(posedge Clk); #1;
         exp_last = g;
         ReqValid = '0;
         hold = $urandom_range(0, 3);
         RespReady = (hold == 0);
         for (int i = 0; i < N; i++) set_data(i, W'($urandom), W'($urandom));
         wait_resp(lat);
         repeat (hold) begin @(posedge Clk); #1; end
         total++;
         if ({RespValid, RespId, Quotient, Remainder, DivByZero} !==
             {1'b1, IDW'(g), exp_q(a[g], b[g]), exp_r(a[g], b[g]), (b[g] == 0)} || lat !== exp_lat(b[g])) begin
            bad++;
            $display("FAIL rand_result_%0d: got v=%b id=%0d q=%0d r=%0d z=%b lat=%0d want id=%0d q=%0d r=%0d lat=%0d",
                     it, RespValid, RespId, Quotient, Remainder, DivByZero, lat, g,
                     exp_q(a[g], b[g]), exp_r(a[g], b[g]), exp_lat(b[g]));
         end
         RespReady = 1'b1;
         @(posedge Clk); #1;
      end
   endtask

   initial begin
      ReqValid    = '0;
      ReqDividend = '0;
      ReqDivider  = '0;
      RespReady   = 1'b1;
      test_reset();
      test_basic();
      test_boundaries();
      test_div_zero();
      test_round_robin();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Round-robin scheduler that shares one iterative unsigned divider among NUM_REQ requesters. It accepts one request at a time through a per-requester valid/ready handshake and runs a restoring division at one quotient bit per cycle. It returns quotient and remainder tagged with the requester index through a valid/ready response port. It sits between multiple arithmetic clients and a single shared division resource.

## Interface
- INPUT_BIT_WIDTH, 8: operand and result width W (≥2)
- NUM_REQ, 4: number of requesters (≥2)
- ID_WIDTH, $clog2(NUM_REQ): width of RespId
- Clk  input  1  clock, all state on rising edge
- Rst_n  input  1  asynchronous active-low reset
- ReqValid  input  NUM_REQ  request pending, bit i = requester i
- ReqDividend  input  NUM_REQ*W  dividend of requester i at bits [i*W +: W]
- ReqDivider  input  NUM_REQ*W  divider of requester i at bits [i*W +: W]
- ReqReady  output  NUM_REQ  one-hot grant; request i accepted on edge where ReqValid[i] & ReqReady[i]
- RespValid  output  1  result available
- RespReady  input  1  consumer accepts result
- RespId  output  ID_WIDTH  index of requester owning result
- Quotient  output  W  floor(Dividend / Divider)
- Remainder  output  W  Dividend mod Divider
- DivByZero  output  1  captured divider was 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ReqReady combinationally one-hot for the first requester with ReqValid set, searching from Last+1 upward with wrap to 0; all-zero if no ReqValid. On accept: latch dividend/divider, RespId <= granted index, Last <= granted index, step counter <= 0, go RUN.
- ReqReady is 0 in RUN and DONE.
- RUN: one restoring step per cycle on a W+1-bit partial remainder: shift in next dividend MSB, subtract divider, restore on negative (bit W set) with quotient bit 0, else quotient bit 1. After W steps go DONE.
- DONE: RespValid=1; Quotient, Remainder, RespId, DivByZero are stable. On RespValid & RespReady go IDLE.
- Divider 0: result is Quotient = all-ones and Remainder = dividend, with DivByZero=1. This holds with or without the macro.
- Requester data may change after acceptance without affecting the operation.
- No back-to-back accept in the DONE→IDLE cycle; the next grant is evaluated in IDLE.

## Timing
- Reset (async, Rst_n=0): state IDLE, Last=NUM_REQ-1 (requester 0 has first priority). Quotient, Remainder, RespId, DivByZero, RespValid = 0. Step counter = 0. ReqReady follows IDLE rule once Rst_n=1.
- Accept at edge k → RespValid high after edge k+W (W RUN cycles).
- Minimum spacing between accepts is W+2 edges with RespReady tied 1.
- Reset mid-RUN or mid-DONE: the operation is discarded, no response is issued, Last returns to NUM_REQ-1.
- Simultaneous requests: exactly one grant per accept. A requester just served has lowest priority on the next arbitration.
- A requester deasserting ReqValid in IDLE before acceptance is legal and loses the grant.

## Configuration
- DIVIDER_ARBITER_ZERO_BYPASS_EN
- Defined: divider 0 is detected at accept. The FSM goes IDLE→DONE directly, with RespValid high after edge k and the zero-divide results loaded.
- Undefined: divider 0 runs the full W RUN cycles. The restoring algorithm naturally yields all-ones/dividend, and DivByZero comes from the latched divider.

## Test plan
- W=8, NUM_REQ=4: req0 100/7 → RespId=0, Quotient=14, Remainder=2, DivByZero=0, RespValid exactly 8 edges after accept.
- Boundaries: 255/1 → Q=255, R=0. 200/255 → Q=0, R=200. 255/255 → Q=1, R=0. 128/3 → Q=42, R=2.
- ReqValid=4'b1111 held, RespReady=1 → grant order 0,1,2,3,0. Only req2 and req3 pending after serving 2 → next grant is 3.
- 77/0 → Q=255, R=77, DivByZero=1. Latency 8 edges without the macro, 0 edges (RespValid after accept edge) with it.
- Hold RespReady=0 for 5 cycles in DONE → RespValid, Quotient, Remainder, RespId unchanged and ReqReady=0. Release → IDLE next edge.
- Assert Rst_n=0 at RUN step 4 → all outputs 0 immediately and no response. After release with ReqValid=4'b1010 → requester 1 granted first.
